// File: rtl/abp_rx_seq_ctrl_if.sv
// Handshake bundle between the ABP receive sequencer, the frame-capture block,
// the downstream payload sink and the ack transmitter.
interface abp_rx_seq_ctrl_if;
  logic frm_valid;
  logic frm_seq;
  logic frm_err;
  logic frm_ack;
  logic dlv_valid;
  logic dlv_ready;
  logic ack_start;
  logic ack_bit;
  logic ack_busy;

  modport master (
    input  frm_valid, frm_seq, frm_err, dlv_ready, ack_busy,
    output frm_ack, dlv_valid, ack_start, ack_bit
  );

  modport slave (
    output frm_valid, frm_seq, frm_err, dlv_ready, ack_busy,
    input  frm_ack, dlv_valid, ack_start, ack_bit
  );
endinterface

// File: rtl/abp_rx_seq_ctrl.sv
// ABP receive sequencer: classifies captured frames as new/duplicate/errored,
// gates delivery downstream, schedules acks and keeps saturating statistics.
module abp_rx_seq_ctrl #(
  parameter int unsigned DLV_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  abp_rx_seq_ctrl_if.master bus,
  output logic              expected_bit,
  output logic [CNT_W-1:0]  dup_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  drop_count
);

  typedef enum logic [2:0] {
    IDLE,
    DELIVER,
    ACK_REQ,
    ACK_WAIT,
    RELEASE
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(DLV_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state;
  logic [15:0] timer;
  logic [1:0]  ack_wait_cnt;
  logic        seen_busy;

  // Pulse outputs default low every cycle; each branch that leaves for
  // RELEASE or ACK_WAIT raises the matching pulse so it lands in that state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      expected_bit  <= 1'b0;
      bus.ack_bit   <= 1'b0;
      bus.frm_ack   <= 1'b0;
      bus.dlv_valid <= 1'b0;
      bus.ack_start <= 1'b0;
      dup_count     <= '0;
      err_count     <= '0;
      drop_count    <= '0;
      timer         <= '0;
      ack_wait_cnt  <= '0;
      seen_busy     <= 1'b0;
    end else begin
      bus.frm_ack   <= 1'b0;
      bus.ack_start <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.frm_valid) begin
            if (bus.frm_err) begin
              if (err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
              bus.frm_ack <= 1'b1;
              state       <= RELEASE;
            end else if (bus.frm_seq == expected_bit) begin
              bus.dlv_valid <= 1'b1;
              timer         <= '0;
              state         <= DELIVER;
            end else begin
              // Duplicate: the sender missed our ack, so repeat it for its bit.
              if (dup_count != CNT_MAX) dup_count <= dup_count + CNT_W'(1);
              bus.ack_bit <= bus.frm_seq;
              state       <= ACK_REQ;
            end
          end
        end

        DELIVER: begin
          if (bus.dlv_ready) begin
            bus.dlv_valid <= 1'b0;
            bus.ack_bit   <= expected_bit;
            expected_bit  <= ~expected_bit;
            state         <= ACK_REQ;
          end else if (timer == TIMER_LAST) begin
            bus.dlv_valid <= 1'b0;
            if (drop_count != CNT_MAX) drop_count <= drop_count + CNT_W'(1);
            bus.frm_ack   <= 1'b1;
            state         <= RELEASE;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        ACK_REQ: begin
          if (!bus.ack_busy) begin
            bus.ack_start <= 1'b1;
            seen_busy     <= 1'b0;
            ack_wait_cnt  <= '0;
            state         <= ACK_WAIT;
          end
        end

        // A transmitter that never raises busy within four cycles is taken
        // to have finished instantly, so a silent transmitter cannot stall us.
        ACK_WAIT: begin
          if (seen_busy) begin
            if (!bus.ack_busy) begin
              bus.frm_ack <= 1'b1;
              state       <= RELEASE;
            end
          end else if (bus.ack_busy) begin
            seen_busy <= 1'b1;
          end else if (ack_wait_cnt == 2'd3) begin
            bus.frm_ack <= 1'b1;
            state       <= RELEASE;
          end else begin
            ack_wait_cnt <= ack_wait_cnt + 2'd1;
          end
        end

        RELEASE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_abp_rx_seq_ctrl.sv
// Directed plus randomized bench for abp_rx_seq_ctrl against a frame-level
// model of the alternating-bit receive rules.
module tb_abp_rx_seq_ctrl;
  localparam int unsigned DLV_TIMEOUT = 16;
  localparam int unsigned CNT_W       = 3;
  localparam int          CNT_MAX     = (1 << CNT_W) - 1;
  localparam int          FRAME_LIMIT = 200;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic             expected_bit;
  logic [CNT_W-1:0] dup_count;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] drop_count;

  abp_rx_seq_ctrl_if bus ();

  abp_rx_seq_ctrl #(
    .DLV_TIMEOUT(DLV_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .bus         (bus),
    .expected_bit(expected_bit),
    .dup_count   (dup_count),
    .err_count   (err_count),
    .drop_count  (drop_count)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level model state
  int m_exp, m_dup, m_err, m_drop;

  // Per-frame observations
  int   cyc, dlv_cyc, first_dlv, xfers, starts, frm_acks;
  int   tx_left, hold_left, ready_delay;
  logic ack_seen_bit, in_flight, prev_busy, done;

  int delay_pool [7] = '{0, 1, 2, 5, 15, 16, 20};

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock of environment: observe DUT at the negedge, then drive the
  // downstream sink and ack transmitter for the next rising edge.
  task automatic step();
    @(negedge aclk);
    cyc++;
    if (bus.dlv_valid) begin
      dlv_cyc++;
      if (first_dlv == 0) first_dlv = cyc;
    end
    if (in_flight) check_output("ack_bit_stable", bus.ack_bit, ack_seen_bit);
    if (bus.ack_start) begin
      starts++;
      check_output("ack_start_while_busy", prev_busy, 0);
      ack_seen_bit = bus.ack_bit;
      in_flight    = 1'b1;
      tx_left      = 3;
    end
    if (bus.frm_ack) begin
      frm_acks++;
      bus.frm_valid = 1'b0;
      done = 1'b1;
    end
    if (hold_left > 0) hold_left--;
    bus.ack_busy = (hold_left > 0) || (tx_left > 0);
    if (tx_left > 0) tx_left--;
    else if (!bus.ack_start) in_flight = 1'b0;
    prev_busy = bus.ack_busy;
    bus.dlv_ready = bus.dlv_valid && (dlv_cyc > ready_delay);
    if (bus.dlv_valid && bus.dlv_ready) xfers++;
  endtask

  task automatic apply_reset();
    aresetn       = 1'b0;
    bus.frm_valid = 1'b0;
    bus.frm_seq   = 1'b0;
    bus.frm_err   = 1'b0;
    bus.dlv_ready = 1'b0;
    bus.ack_busy  = 1'b0;
    tx_left = 0; hold_left = 0; in_flight = 1'b0; prev_busy = 1'b0;
    m_exp = 0; m_dup = 0; m_err = 0; m_drop = 0;
    repeat (3) @(negedge aclk);
    check_output("rst_expected_bit", expected_bit, 0);
    check_output("rst_ack_bit", bus.ack_bit, 0);
    check_output("rst_frm_ack", bus.frm_ack, 0);
    check_output("rst_dlv_valid", bus.dlv_valid, 0);
    check_output("rst_ack_start", bus.ack_start, 0);
    check_output("rst_counters", {dup_count, err_count, drop_count}, 0);
    aresetn = 1'b1;
  endtask

  // Present one frame, run it to its frm_ack and compare against the model.
  task automatic apply_stimulus(input string tag, input logic seq, input logic err,
                                input int delay, input int hold);
    int e_xfer, e_ack, e_ackbit, e_drop, e_new;
    e_xfer = 0; e_ack = 0; e_ackbit = 0; e_drop = 0;
    e_new  = (!err && (int'(seq) == m_exp)) ? 1 : 0;
    if (err) m_err = sat_inc(m_err);
    else if (e_new == 1) begin
      if (delay < int'(DLV_TIMEOUT)) begin
        e_xfer = 1; e_ack = 1; e_ackbit = m_exp; m_exp ^= 1;
      end else begin
        e_drop = 1; m_drop = sat_inc(m_drop);
      end
    end else begin
      e_ack = 1; e_ackbit = int'(seq); m_dup = sat_inc(m_dup);
    end

    cyc = 0; dlv_cyc = 0; first_dlv = 0; xfers = 0; starts = 0; frm_acks = 0;
    done = 1'b0; ready_delay = delay; hold_left = hold;
    bus.ack_busy  = (hold > 0);
    prev_busy     = bus.ack_busy;
    bus.dlv_ready = 1'b0;
    bus.frm_seq   = seq;
    bus.frm_err   = err;
    bus.frm_valid = 1'b1;

    while (!done && cyc < FRAME_LIMIT) step();
    check_output({tag, "/frm_ack_seen"}, done, 1);
    check_output({tag, "/xfers"}, xfers, e_xfer);
    check_output({tag, "/ack_starts"}, starts, e_ack);
    if (e_ack == 1) check_output({tag, "/ack_bit"}, ack_seen_bit, e_ackbit);
    if (e_new == 1) check_output({tag, "/dlv_latency"}, first_dlv, 1);
    else check_output({tag, "/no_dlv"}, dlv_cyc, 0);
    if (e_drop == 1) check_output({tag, "/dlv_cycles"}, dlv_cyc, DLV_TIMEOUT);
    check_output({tag, "/expected_bit"}, expected_bit, m_exp);
    check_output({tag, "/dup_count"}, dup_count, m_dup);
    check_output({tag, "/err_count"}, err_count, m_err);
    check_output({tag, "/drop_count"}, drop_count, m_drop);
    step();
    check_output({tag, "/frm_ack_single"}, frm_acks, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    logic seq;
    logic err;
    int   dly;
    int   hold;

    $display("[TB] starting abp_rx_seq_ctrl bench");
    @(negedge aclk);
    apply_reset();

    apply_stimulus("new0", 1'b0, 1'b0, 0, 0);
    apply_stimulus("new1", 1'b1, 1'b0, 0, 0);
    apply_stimulus("new0b", 1'b0, 1'b0, 0, 0);
    apply_stimulus("dup0", 1'b0, 1'b0, 0, 0);
    apply_stimulus("err", 1'b1, 1'b1, 0, 0);
    apply_stimulus("timeout", 1'b1, 1'b0, 30, 0);
    apply_stimulus("resend", 1'b1, 1'b0, 0, 0);
    apply_stimulus("ready_at_expiry", 1'b0, 1'b0, 15, 0);
    apply_stimulus("ready_late", 1'b1, 1'b0, 16, 0);
    apply_stimulus("busy_hold", 1'b1, 1'b0, 0, 20);
    apply_stimulus("busy_hold_dup", 1'b1, 1'b0, 2, 20);

    // Reset while a new frame sits in delivery.
    cyc = 0; dlv_cyc = 0; first_dlv = 0; xfers = 0; starts = 0; frm_acks = 0;
    done = 1'b0; ready_delay = 1000; hold_left = 0;
    bus.frm_seq = m_exp[0]; bus.frm_err = 1'b0; bus.frm_valid = 1'b1;
    repeat (5) step();
    check_output("pre_rst_dlv_valid", bus.dlv_valid, 1);
    aresetn = 1'b0;
    #1;
    check_output("mid_rst_dlv_valid", bus.dlv_valid, 0);
    check_output("mid_rst_expected_bit", expected_bit, 0);
    check_output("mid_rst_counters", {dup_count, err_count, drop_count}, 0);
    apply_reset();
    apply_stimulus("post_rst_new0", 1'b0, 1'b0, 0, 0);

    // Randomized frames; small CNT_W drives the counters into saturation.
    for (int i = 0; i < 60; i++) begin
      seq  = 1'($urandom_range(0, 1));
      err  = ($urandom_range(0, 3) == 0);
      dly  = delay_pool[$urandom_range(0, 6)];
      hold = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 20)) : 0;
      apply_stimulus($sformatf("rand%0d", i), seq, err, dly, hold);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
